// File: rtl/cb_exec.sv
// CB-prefix executor: sequences one rotate/shift/BIT/RES/SET on a register or (HL) through an external bit_ops unit.
// Latency: register operand 2 cycles start->done; (HL) operand 3 (BIT) or 4 cycles plus one per memory wait cycle.
// Backpressure: memory requests are held until mem_ack; start is ignored while busy.
module cb_exec (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  cb_opcode,
    input  logic [3:0]  flags_in,
    input  logic [15:0] hl_in,
    output logic        busy,
    output logic        done,
    output logic [2:0]  reg_rd_sel,
    input  logic [7:0]  reg_rd_data,
    output logic        reg_wr_en,
    output logic [2:0]  reg_wr_sel,
    output logic [7:0]  reg_wr_data,
    output logic        flags_wr_en,
    output logic [3:0]  flags_out,
    output logic [15:0] mem_addr,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [4:0]  alu_op,
    output logic [7:0]  alu_in,
    output logic        alu_c_in,
    input  logic [7:0]  alu_out,
    input  logic        alu_c,
    input  logic        alu_z,
    input  logic        alu_h
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REG,
        S_MEM_RD,
        S_MEM_EXEC,
        S_MEM_WR,
        S_DONE
    } state_t;

    localparam logic [2:0] IDX_HL = 3'd6;

    state_t      state_q;
    logic [7:0]  op_q;
    logic        c_q;
    logic [7:0]  opnd_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  res_q;
    logic [3:0]  flags_q;
    logic        busy_q;
    logic        done_q;
    logic        reg_wr_en_q;
    logic        flags_wr_en_q;
    logic        rd_req_q;
    logic        wr_req_q;

    logic        is_bit;
    logic        writes_flags;
    logic [3:0]  flags_d;

    // Half-carry comes straight from the op class, so the ALU's h output and
    // the incoming Z/N/H flags are not needed here.
    logic        unused_ok;
    assign unused_ok = &{1'b0, alu_h, flags_in[3:1]};

    assign is_bit       = (op_q[7:6] == 2'b01);
    assign writes_flags = ~op_q[7];

    // New flag nibble: shifts take Z/C from the ALU, BIT keeps the latched carry.
    always_comb begin
        flags_d = {alu_z, 1'b0, 1'b0, alu_c};
        if (is_bit) begin
            flags_d = {alu_z, 1'b0, 1'b1, c_q};
        end
    end

    // Operand routing into the ALU and register-file read port.
    always_comb begin
        alu_in     = 8'h00;
        reg_rd_sel = 3'd0;
        if (state_q == S_REG) begin
            reg_rd_sel = op_q[2:0];
            alu_in     = reg_rd_data;
        end else if (state_q == S_MEM_EXEC) begin
            alu_in = opnd_q;
        end
    end

    assign alu_op      = op_q[7:3];
    assign alu_c_in    = c_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign reg_wr_sel  = op_q[2:0];
    assign reg_wr_data = res_q;
    assign flags_wr_en = flags_wr_en_q;
    assign flags_out   = flags_q;
    assign mem_addr    = addr_q;
    assign mem_rd_req  = rd_req_q;
    assign mem_wr_req  = wr_req_q;
    assign mem_wdata   = wdata_q;

    // Control FSM; every visible strobe is a register set on entry to its state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            op_q          <= 8'h00;
            c_q           <= 1'b0;
            opnd_q        <= 8'h00;
            addr_q        <= 16'h0000;
            wdata_q       <= 8'h00;
            res_q         <= 8'h00;
            flags_q       <= 4'h0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            reg_wr_en_q   <= 1'b0;
            flags_wr_en_q <= 1'b0;
            rd_req_q      <= 1'b0;
            wr_req_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= cb_opcode;
                        c_q    <= flags_in[0];
                        busy_q <= 1'b1;
                        if (cb_opcode[2:0] == IDX_HL) begin
                            addr_q   <= hl_in;
                            rd_req_q <= 1'b1;
                            state_q  <= S_MEM_RD;
                        end else begin
                            state_q <= S_REG;
                        end
                    end
                end
                S_REG: begin
                    res_q         <= alu_out;
                    flags_q       <= writes_flags ? flags_d : 4'h0;
                    reg_wr_en_q   <= ~is_bit;
                    flags_wr_en_q <= writes_flags;
                    done_q        <= 1'b1;
                    state_q       <= S_DONE;
                end
                S_MEM_RD: begin
                    if (mem_ack) begin
                        opnd_q   <= mem_rdata;
                        rd_req_q <= 1'b0;
                        state_q  <= S_MEM_EXEC;
                    end
                end
                S_MEM_EXEC: begin
                    wdata_q <= alu_out;
                    flags_q <= writes_flags ? flags_d : 4'h0;
                    if (is_bit) begin
                        flags_wr_en_q <= 1'b1;
                        done_q        <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        wr_req_q <= 1'b1;
                        state_q  <= S_MEM_WR;
                    end
                end
                S_MEM_WR: begin
                    if (mem_ack) begin
                        wr_req_q      <= 1'b0;
                        flags_wr_en_q <= writes_flags;
                        done_q        <= 1'b1;
                        state_q       <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q        <= 1'b0;
                    reg_wr_en_q   <= 1'b0;
                    flags_wr_en_q <= 1'b0;
                    busy_q        <= 1'b0;
                    addr_q        <= 16'h0000;
                    state_q       <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cb_exec.sv
// Testbench for cb_exec: register file, memory responder and bit_ops stand-in around the DUT.
// Latency: each operation is tracked start->done against the expected cycle count.
// Backpressure: memory ack inserted after a programmable number of wait cycles.
module tb_cb_exec;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cb_opcode = 8'h00;
    logic [3:0]  flags_in = 4'h0;
    logic [15:0] hl_in = 16'h0000;
    logic        busy, done, reg_wr_en, flags_wr_en, mem_rd_req, mem_wr_req;
    logic [2:0]  reg_rd_sel, reg_wr_sel;
    logic [7:0]  reg_rd_data, reg_wr_data, mem_wdata, alu_in, alu_out;
    logic [3:0]  flags_out;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic [4:0]  alu_op;
    logic        alu_c_in, alu_c, alu_z, alu_h;
    logic [9:0]  alu_res;

    logic [7:0]  regs [8];
    logic [7:0]  mem_val = 8'h00;
    int          waits = 0;
    int          wait_cnt = 0;
    int          wr_cnt = 0;
    logic [15:0] wr_addr = 16'h0;
    logic [7:0]  wr_data = 8'h0;
    int          n_chk = 0;
    int          n_fail = 0;

    cb_exec dut (
        .clock(clock), .reset_n(reset_n), .start(start), .cb_opcode(cb_opcode),
        .flags_in(flags_in), .hl_in(hl_in), .busy(busy), .done(done),
        .reg_rd_sel(reg_rd_sel), .reg_rd_data(reg_rd_data), .reg_wr_en(reg_wr_en),
        .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data), .flags_wr_en(flags_wr_en),
        .flags_out(flags_out), .mem_addr(mem_addr), .mem_rd_req(mem_rd_req),
        .mem_wr_req(mem_wr_req), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .alu_op(alu_op), .alu_in(alu_in), .alu_c_in(alu_c_in),
        .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_h(alu_h)
    );

    always #5 clock = ~clock;

    // Architectural CB semantics: returns {result, Z, C}.
    function automatic logic [9:0] cb_ref(input logic [7:0] op, input logic [7:0] v, input logic c);
        logic [7:0] r;
        logic       co;
        logic       z;
        int         b;
        b  = int'(op[5:3]);
        r  = v;
        co = c;
        case (op[7:6])
            2'b00: begin
                case (op[5:3])
                    3'd0: begin r = {v[6:0], v[7]}; co = v[7]; end
                    3'd1: begin r = {v[0], v[7:1]}; co = v[0]; end
                    3'd2: begin r = {v[6:0], c};    co = v[7]; end
                    3'd3: begin r = {c, v[7:1]};    co = v[0]; end
                    3'd4: begin r = {v[6:0], 1'b0}; co = v[7]; end
                    3'd5: begin r = {v[7], v[7:1]}; co = v[0]; end
                    3'd6: begin r = {v[3:0], v[7:4]}; co = 1'b0; end
                    default: begin r = {1'b0, v[7:1]}; co = v[0]; end
                endcase
            end
            2'b01: r = v;
            2'b10: r[b] = 1'b0;
            default: r[b] = 1'b1;
        endcase
        z = (op[7:6] == 2'b01) ? ~v[b] : (r == 8'h00);
        return {r, z, co};
    endfunction

    // bit_ops stand-in driven from the DUT's alu_op/alu_in/alu_c_in.
    assign alu_res     = cb_ref({alu_op, 3'b000}, alu_in, alu_c_in);
    assign alu_out     = alu_res[9:2];
    assign alu_z       = alu_res[1];
    assign alu_c       = alu_res[0];
    assign alu_h       = (alu_op[4:3] == 2'b01);
    assign reg_rd_data = regs[reg_rd_sel];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory responder: acks after `waits` idle cycles, records writes.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_rd_req || mem_wr_req) begin
                if (mem_rd_req && mem_wr_req) check_eq("rd_wr_exclusive", 32'd1, 32'd0);
                if (wait_cnt == waits) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    if (mem_rd_req) begin
                        mem_rdata = mem_val;
                    end else begin
                        wr_cnt++;
                        wr_addr = mem_addr;
                        wr_data = mem_wdata;
                        mem_val = mem_wdata;
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic run_op(input string tag, input logic [7:0] op, input logic [7:0] v, input logic c,
                          input logic [15:0] hl, input int w, input logic [7:0] exp_res,
                          input logic [3:0] exp_flags, input bit extra);
        bit is_bit, is_mem, seen;
        int lat, n, wc0, extra_d;
        is_bit = (op[7:6] == 2'b01);
        is_mem = (op[2:0] == 3'd6);
        lat    = !is_mem ? 2 : (is_bit ? 3 + w : 4 + 2 * w);
        waits  = w;
        if (is_mem) mem_val = v;
        else regs[op[2:0]] = v;
        wc0 = wr_cnt;
        @(negedge clock);
        start     = 1'b1;
        cb_opcode = op;
        flags_in  = {3'($urandom), c};
        hl_in     = hl;
        seen = 1'b0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (n == 1) begin
                start = extra;
                check_eq({tag, ".busy"}, 32'(busy), 32'd1);
            end else if (n == 2) begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check_eq({tag, ".latency"}, seen ? n : 0, lat);
        check_eq({tag, ".reg_wr_en"}, 32'(reg_wr_en), 32'(!is_mem && !is_bit));
        if (!is_mem && !is_bit) begin
            check_eq({tag, ".reg_wr_sel"}, 32'(reg_wr_sel), 32'(op[2:0]));
            check_eq({tag, ".reg_wr_data"}, 32'(reg_wr_data), 32'(exp_res));
            regs[op[2:0]] = exp_res;
        end
        check_eq({tag, ".flags_wr_en"}, 32'(flags_wr_en), 32'(!op[7]));
        if (!op[7]) check_eq({tag, ".flags"}, 32'(flags_out), 32'(exp_flags));
        if (is_mem && !is_bit) begin
            check_eq({tag, ".mem_writes"}, wr_cnt - wc0, 1);
            check_eq({tag, ".mem_wr_addr"}, 32'(wr_addr), 32'(hl));
            check_eq({tag, ".mem_wr_data"}, 32'(wr_data), 32'(exp_res));
        end else begin
            check_eq({tag, ".mem_writes"}, wr_cnt - wc0, 0);
        end
        extra_d = 0;
        @(negedge clock);
        check_eq({tag, ".idle_busy"}, 32'(busy), 32'd0);
        extra_d += int'(done);
        repeat (3) begin
            @(negedge clock);
            extra_d += int'(done);
        end
        check_eq({tag, ".extra_done"}, extra_d, 0);
    endtask

    initial begin
        logic [9:0] r;
        logic [7:0] op, v;
        logic [3:0] fl;
        logic       c;
        int         k, wc0, dcnt;
        for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);

        repeat (2) @(negedge clock);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
        check_eq("rst.mem_req", 32'({mem_rd_req, mem_wr_req}), 32'd0);
        check_eq("rst.mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst.flags_out", 32'(flags_out), 32'd0);
        check_eq("rst.alu_op", 32'(alu_op), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_op("rlc_b",      8'h00, 8'h85, 1'b0, 16'h0000, 0, 8'h0B, 4'b0001, 1'b0);
        run_op("bit7_a",     8'h7F, 8'h00, 1'b1, 16'h0000, 0, 8'h00, 4'b1011, 1'b0);
        run_op("set3_hl",    8'hDE, 8'h00, 1'b0, 16'hC000, 2, 8'h08, 4'b0000, 1'b0);
        run_op("swap_hl",    8'h36, 8'hF0, 1'b0, 16'h8001, 0, 8'h0F, 4'b0000, 1'b0);
        run_op("srl_a",      8'h3F, 8'h01, 1'b0, 16'h0000, 0, 8'h00, 4'b1001, 1'b1);

        // Reset while the write-back request is outstanding.
        waits   = 3;
        mem_val = 8'h55;
        wc0     = wr_cnt;
        @(negedge clock);
        start = 1'b1; cb_opcode = 8'hDE; hl_in = 16'h1234; flags_in = 4'h0;
        @(negedge clock);
        start = 1'b0;
        for (k = 0; k < 30; k++) begin
            if (mem_wr_req) break;
            @(negedge clock);
        end
        check_eq("rst_mid.reached_wr", 32'(mem_wr_req), 32'd1);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_mid.wr_req", 32'(mem_wr_req), 32'd0);
        check_eq("rst_mid.busy", 32'(busy), 32'd0);
        check_eq("rst_mid.mem_addr", 32'(mem_addr), 32'd0);
        dcnt = 0;
        repeat (3) begin
            @(negedge clock);
            dcnt += int'(done);
        end
        check_eq("rst_mid.no_done", dcnt, 0);
        check_eq("rst_mid.no_write", wr_cnt - wc0, 0);
        reset_n = 1'b1;
        run_op("post_rst", 8'h06, 8'h81, 1'b0, 16'h4000, 1, 8'h03, 4'b0001, 1'b0);

        for (int t = 0; t < 40; t++) begin
            op = 8'($urandom);
            v  = 8'($urandom);
            c  = 1'($urandom);
            r  = cb_ref(op, v, c);
            fl = (op[7:6] == 2'b01) ? {r[1], 1'b0, 1'b1, c} : {r[1], 1'b0, 1'b0, r[0]};
            run_op($sformatf("rnd%0d_op%02h", t, op), op, v, c, 16'($urandom), $urandom_range(0, 2),
                   r[9:2], fl, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cb_exec.md
CB_EXEC -- requirements
Module: cb_exec

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to execute cb_opcode
- cb_opcode  in  8  CB-prefixed opcode byte
- flags_in  in  4  current {Z,N,H,C}
- hl_in  in  16  current HL
- busy  out  1  high while not IDLE
- done  out  1  one-cycle completion pulse
- reg_rd_sel  out  3  register-file read index
- reg_rd_data  in  8  combinational read data
- reg_wr_en  out  1  register write strobe
- reg_wr_sel  out  3  register write index
- reg_wr_data  out  8  register write data
- flags_wr_en  out  1  flag write strobe
- flags_out  out  4  new {Z,N,H,C}
- mem_addr  out  16  memory address
- mem_rd_req / mem_wr_req  out  1  memory read / write request, held until ack
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid with mem_ack
- mem_ack  in  1  completes the pending request; may assert in the request's first cycle
- alu_op  out  5  to bit_ops shift_op
- alu_in  out  8  to bit_ops reg_in
- alu_c_in  out  1  to bit_ops c_in
- alu_out  in  8  bit_ops reg_out
- alu_c, alu_z, alu_h  in  1  bit_ops c_out, z_out, h_out

Function
REQ-003 SHALL latch cb_opcode, flags_in[0] and hl_in when start is high in IDLE; start SHALL be ignored in every other state.
REQ-004 SHALL drive alu_op = {op[7:6], op[5:3]}, alu_c_in = latched C, and alu_in = the current operand.
REQ-005 Operand index op[2:0] SHALL map as: 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 (HL), 7 A.
REQ-006 States SHALL be IDLE, REG, MEM_RD, MEM_EXEC, MEM_WR and DONE.
- IDLE + start: go to REG when index ≠ 6, else MEM_RD.
REQ-007 REG:
- reg_rd_sel = index; alu_in = reg_rd_data.
- At the clock edge, register the write/flag outputs, then go to DONE.
REQ-008 MEM_RD:
- mem_rd_req = 1, mem_addr = latched HL.
- On mem_ack, capture mem_rdata as the operand and go to MEM_EXEC.
REQ-009 MEM_EXEC:
- alu_in = captured operand; register flags and mem_wdata = alu_out.
- Go to DONE for BIT (op[7:6] = 01); otherwise go to MEM_WR.
REQ-010 MEM_WR:
- mem_wr_req = 1, mem_addr = latched HL; on mem_ack go to DONE.
REQ-011 DONE SHALL last one cycle and return to IDLE. In DONE:
- done = 1.
- reg_wr_en = 1 only for a register operand and a non-BIT op.
- flags_wr_en = 1 only for op[7:6] ∈ {00, 01}.
REQ-012 Flags for op[7:6] = 00 SHALL be {alu_z, 0, 0, alu_c}.
REQ-013 Flags for BIT SHALL be {alu_z, 0, 1, latched C}.
REQ-014 RES and SET SHALL leave flags untouched (flags_wr_en = 0).
REQ-015 busy SHALL be high in every state except IDLE.
REQ-016 Every strobe SHALL be low outside the states named above; mem_rd_req and mem_wr_req SHALL never assert together.
REQ-017 Latency from the start edge to done high:
- Register operand: 2 cycles.
- (HL) operand with zero-wait ack: 3 cycles for BIT, 4 cycles otherwise.
- Each wait cycle adds 1.

Reset
REQ-018 When reset_n is low, the block SHALL asynchronously enter IDLE and force all outputs to 0, including:
- busy, done, reg_wr_en, flags_wr_en, mem_rd_req, mem_wr_req;
- mem_addr, mem_wdata, reg_wr_data, flags_out, alu_op.
REQ-019 Reset mid-operation SHALL drop any pending memory request immediately, with no write-back; the first start after reset_n deasserts SHALL be accepted.

Verification
REQ-020 RLC B (0x00), B = 0x85, C = 0 -> in the cycle 2 after start: reg_wr B = 0x0B, flags 0001, done.
REQ-021 BIT 7,A (0x7F), A = 0x00, C = 1 -> reg_wr_en = 0, flags 1011, done at cycle 2.
REQ-022 SET 3,(HL) (0xDE), HL = 0xC000, mem = 0x00, ack after 2 wait cycles on each access -> write 0x08 to 0xC000, flags_wr_en = 0, done at cycle 8.
REQ-023 SWAP (HL) (0x36), mem = 0xF0, zero-wait -> write 0x0F, flags 0000, done at cycle 4.
REQ-024 SRL A (0x3F), A = 0x01 -> A = 0x00, flags 1001; a second start while busy produces no extra done.
REQ-025 reset_n low during MEM_WR -> mem_wr_req and busy go low with no clock; no done; a fresh start then completes normally.
